// File: rtl/nwr_pkg.sv
// Shared definitions for the NWRITE traffic generator and receive checker.
package nwr_pkg;

    localparam logic [3:0] FTYPE_NWRITE = 4'h5;
    localparam logic [3:0] TTYPE_NWRITE = 4'h4;

    // Error codes; lower-numbered is not higher priority, the first one seen in a packet wins
    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_NO_LAST    = 3'd1;
    localparam logic [2:0] ERR_EARLY_LAST = 3'd2;
    localparam logic [2:0] ERR_DATA       = 3'd3;
    localparam logic [2:0] ERR_KEEP       = 3'd4;
    localparam logic [2:0] ERR_TYPE       = 3'd5;
    localparam logic [2:0] ERR_SIZE       = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDrain,
        StReport
    } nwr_state_e;

    // Expected tkeep on the final data beat; MSB is the first byte on the wire
    function automatic logic [7:0] last_keep(input logic [11:0] size_m1);
        logic [2:0] rem;
        logic [3:0] sh;
        rem = size_m1[2:0] + 3'd1;
        sh  = 4'd8 - {1'b0, rem};
        if (rem == 3'd0) begin
            return 8'hff;
        end
        return 8'hff << sh;
    endfunction

endpackage

// File: rtl/nwr_keep_calc.sv
// Expected beat count (size word + data beats) and last-beat tkeep for a given size_m1.
module nwr_keep_calc
    import nwr_pkg::*;
(
    input  logic [11:0] i_size_m1,
    output logic [12:0] o_exp_beats,
    output logic [7:0]  o_last_keep
);

    logic [12:0] w_bytes_p7;

    // (size_m1 + 1 + 7) / 8 data beats, plus the leading size beat
    assign w_bytes_p7  = {1'b0, i_size_m1} + 13'd8;
    assign o_exp_beats = 13'd1 + {3'd0, w_bytes_p7[12:3]};
    assign o_last_keep = last_keep(i_size_m1);

endmodule

// File: rtl/nwr_rx_checker.sv
// Target-side sink for incrementing-pattern NWRITE packets: checks size word, +1 data pattern,
// tlast position, tail tkeep and ftype/ttype, then reports per packet with sticky counters.
module nwr_rx_checker
    import nwr_pkg::*;
#(
    parameter logic [3:0]  EXP_FTYPE   = FTYPE_NWRITE,
    parameter logic [3:0]  EXP_TTYPE   = TTYPE_NWRITE,
    parameter logic [11:0] MAX_SIZE_M1 = 12'd1023
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic        user_tvalid_in,
    output logic        user_tready_o,
    input  logic [63:0] user_tdata_in,
    input  logic [7:0]  user_tkeep_in,
    input  logic        user_tlast_in,
    input  logic [33:0] user_addr_in,
    input  logic [3:0]  user_ftype_in,
    input  logic [3:0]  user_ttype_in,
    output logic        pkt_done_o,
    output logic        pkt_err_o,
    output logic [2:0]  err_code_o,
    output logic [33:0] last_addr_o,
    output logic [31:0] pkt_cnt_o,
    output logic [15:0] err_cnt_o
);

    nwr_state_e  r_state;
    logic        r_tready;
    logic [11:0] r_size;
    logic [63:0] r_base;
    logic [33:0] r_addr;
    logic [12:0] r_idx;
    logic [2:0]  r_err;
    logic        r_done;
    logic        r_perr;
    logic [2:0]  r_code;
    logic [33:0] r_last_addr;
    logic [31:0] r_pkt_cnt;
    logic [15:0] r_err_cnt;

    nwr_state_e  w_state_d;
    logic [2:0]  w_err_d;
    logic [2:0]  w_beat_err;
    logic        w_accept;
    logic        w_to_report;
    logic [12:0] w_exp_beats;
    logic [7:0]  w_last_keep;
    logic        w_is_last;
    logic [63:0] w_exp_data;
    logic [7:0]  w_exp_keep;

    nwr_keep_calc u_keep_calc (
        .i_size_m1   (r_size),
        .o_exp_beats (w_exp_beats),
        .o_last_keep (w_last_keep)
    );

    assign w_accept   = user_tvalid_in & r_tready;
    assign w_is_last  = (r_idx == (w_exp_beats - 13'd1));
    assign w_exp_data = r_base + {51'd0, r_idx};
    assign w_exp_keep = w_is_last ? w_last_keep : 8'hff;

    // Next state and first-error tracking for the beat being accepted
    always_comb begin
        w_state_d  = r_state;
        w_err_d    = r_err;
        w_beat_err = ERR_NONE;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    // Beat 0 starts a fresh packet, so its error replaces any old one
                    if (user_tdata_in[63:12] != 52'd0) begin
                        w_err_d = ERR_DATA;
                    end else if ((user_ftype_in != EXP_FTYPE) || (user_ttype_in != EXP_TTYPE)) begin
                        w_err_d = ERR_TYPE;
                    end else if (user_tdata_in[11:0] > MAX_SIZE_M1) begin
                        w_err_d = ERR_SIZE;
                    end else if (user_tlast_in) begin
                        w_err_d = ERR_EARLY_LAST;
                    end else begin
                        w_err_d = ERR_NONE;
                    end
                    w_state_d = user_tlast_in ? StReport : StRecv;
                end
            end
            StRecv: begin
                if (w_accept) begin
                    if (user_tdata_in != w_exp_data) begin
                        w_beat_err = ERR_DATA;
                    end else if (user_tkeep_in != w_exp_keep) begin
                        w_beat_err = ERR_KEEP;
                    end else if (user_tlast_in && !w_is_last) begin
                        w_beat_err = ERR_EARLY_LAST;
                    end else if (!user_tlast_in && w_is_last) begin
                        w_beat_err = ERR_NO_LAST;
                    end
                    if (r_err == ERR_NONE) begin
                        w_err_d = w_beat_err;
                    end
                    if (user_tlast_in) begin
                        w_state_d = StReport;
                    end else if (w_is_last) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Overlong packet: swallow beats unchecked until tlast
                if (w_accept && user_tlast_in) begin
                    w_state_d = StReport;
                end
            end
            StReport: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_to_report = (w_state_d == StReport) && (r_state != StReport);

    // FSM state, packet context and registered report outputs
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_state     <= StIdle;
            r_tready    <= 1'b0;
            r_size      <= 12'd0;
            r_base      <= 64'd0;
            r_addr      <= 34'd0;
            r_idx       <= 13'd0;
            r_err       <= ERR_NONE;
            r_done      <= 1'b0;
            r_perr      <= 1'b0;
            r_code      <= ERR_NONE;
            r_last_addr <= 34'd0;
            r_pkt_cnt   <= 32'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_state  <= w_state_d;
            r_tready <= (w_state_d != StReport);
            r_err    <= w_err_d;
            r_done   <= w_to_report;
            r_perr   <= w_to_report && (w_err_d != ERR_NONE);
            if ((r_state == StIdle) && w_accept) begin
                r_size <= user_tdata_in[11:0];
                r_base <= user_tdata_in;
                r_addr <= user_addr_in;
                r_idx  <= 13'd1;
            end else if ((r_state == StRecv) && w_accept) begin
                r_idx <= r_idx + 13'd1;
            end
            if (w_to_report) begin
                r_code      <= w_err_d;
                // A one-beat packet reports before r_addr has been loaded
                r_last_addr <= (r_state == StIdle) ? user_addr_in : r_addr;
                r_pkt_cnt   <= r_pkt_cnt + 32'd1;
                if ((w_err_d != ERR_NONE) && (r_err_cnt != 16'hffff)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign user_tready_o = r_tready;
    assign pkt_done_o    = r_done;
    assign pkt_err_o     = r_perr;
    assign err_code_o    = r_code;
    assign last_addr_o   = r_last_addr;
    assign pkt_cnt_o     = r_pkt_cnt;
    assign err_cnt_o     = r_err_cnt;

endmodule
